// File: rtl/tag_resolver.sv
// Resolves a captured row of CAM match flags into a stream of row addresses, lowest index first,
// with a valid/ready handshake, an optional first-match-only mode and an abort.
module tag_resolver #(
  parameter int DATA_DEPTH     = 16,
  parameter int ADDR_WIDTH_CAM = 8
) (
  input  logic                      clk,
  input  logic                      rstIn,
  input  logic [DATA_DEPTH-1:0]     tag_row,
  input  logic                      start,
  input  logic                      first_only,
  input  logic                      abort,
  output logic [ADDR_WIDTH_CAM-1:0] out_addr,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic                      busy,
  output logic                      done,
  output logic                      no_match,
  output logic [ADDR_WIDTH_CAM:0]   match_cnt
);

  localparam int CNT_W = ADDR_WIDTH_CAM + 1;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [1:0]            state_q, state_d;
  logic [DATA_DEPTH-1:0] tag_buf_q, tag_buf_d;
  logic                  first_only_q, first_only_d;
  logic [CNT_W-1:0]      match_cnt_q, match_cnt_d;
  logic                  no_match_q, no_match_d;

  logic                  handshake;
  logic [DATA_DEPTH-1:0] tag_buf_dropped;

  assign out_valid = (state_q == ST_SCAN) && (tag_buf_q != '0);
  assign busy      = (state_q == ST_SCAN);
  assign done      = (state_q == ST_DONE);
  assign no_match  = no_match_q;
  assign match_cnt = match_cnt_q;
  assign handshake = out_valid && out_ready;

  // x & (x-1) drops exactly the lowest set bit, i.e. the address being accepted.
  assign tag_buf_dropped = tag_buf_q & (tag_buf_q - DATA_DEPTH'(1));

  always_comb begin
    out_addr = '0;
    for (int i = DATA_DEPTH - 1; i >= 0; i--) begin
      if (tag_buf_q[i]) out_addr = ADDR_WIDTH_CAM'(i);
    end
    if (!out_valid) out_addr = '0;
  end

  always_comb begin
    state_d      = state_q;
    tag_buf_d    = tag_buf_q;
    first_only_d = first_only_q;
    match_cnt_d  = match_cnt_q;
    no_match_d   = no_match_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          tag_buf_d    = tag_row;
          first_only_d = first_only;
          match_cnt_d  = '0;
          no_match_d   = 1'b0;
          state_d      = ST_SCAN;
        end
      end
      ST_SCAN: begin
        if (abort) begin
          tag_buf_d = '0;
          state_d   = ST_IDLE;
        end else begin
          if (handshake) begin
            tag_buf_d   = tag_buf_dropped;
            match_cnt_d = match_cnt_q + CNT_W'(1);
          end
          // Leftover bits in first-only mode are discarded so the buffer is empty outside SCAN.
          if ((tag_buf_d == '0) || (handshake && first_only_q)) begin
            tag_buf_d  = '0;
            no_match_d = (match_cnt_d == '0);
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstIn) begin
    if (!rstIn) begin
      state_q      <= ST_IDLE;
      tag_buf_q    <= '0;
      first_only_q <= 1'b0;
      match_cnt_q  <= '0;
      no_match_q   <= 1'b0;
    end else begin
      state_q      <= state_d;
      tag_buf_q    <= tag_buf_d;
      first_only_q <= first_only_d;
      match_cnt_q  <= match_cnt_d;
      no_match_q   <= no_match_d;
    end
  end

endmodule

// File: tb/tb_tag_resolver.sv
// Bench for tag_resolver: a queue-based reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_tag_resolver;

  logic        clk;
  logic        rstIn;
  logic [15:0] tag_row;
  logic        start;
  logic        first_only;
  logic        abort;
  logic [7:0]  out_addr;
  logic        out_valid;
  logic        out_ready;
  logic        busy;
  logic        done;
  logic        no_match;
  logic [8:0]  match_cnt;

  int nChecks = 0;
  int nFail   = 0;

  // Reference model: pending addresses as a queue plus the resolution phase.
  int mQ[$];
  int mPhase;
  bit mFo;
  int mCnt;
  bit mNm;

  tag_resolver #(.DATA_DEPTH(16), .ADDR_WIDTH_CAM(8)) dut (
    .clk(clk), .rstIn(rstIn), .tag_row(tag_row), .start(start),
    .first_only(first_only), .abort(abort), .out_addr(out_addr),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy),
    .done(done), .no_match(no_match), .match_cnt(match_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input int act, input int exp);
    nChecks++;
    if (act != exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0d, expected %0d at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic resetModel();
    mQ.delete();
    mPhase = 0;
    mFo    = 1'b0;
    mCnt   = 0;
    mNm    = 1'b0;
  endtask

  task automatic stepModel();
    bit v;
    v = (mPhase == 1) && (mQ.size() > 0);
    if (!rstIn) begin
      resetModel();
    end else if (mPhase == 0) begin
      if (start) begin
        mQ.delete();
        for (int i = 0; i < 16; i++) if (tag_row[i]) mQ.push_back(i);
        mFo    = first_only;
        mCnt   = 0;
        mNm    = 1'b0;
        mPhase = 1;
      end
    end else if (mPhase == 1) begin
      if (abort) begin
        mQ.delete();
        mPhase = 0;
      end else if (v && out_ready) begin
        void'(mQ.pop_front());
        mCnt++;
        if (mFo || mQ.size() == 0) begin
          mQ.delete();
          mNm    = (mCnt == 0);
          mPhase = 2;
        end
      end else if (mQ.size() == 0) begin
        mNm    = (mCnt == 0);
        mPhase = 2;
      end
    end else begin
      mPhase = 0;
    end
  endtask

  always @(negedge rstIn) resetModel();

  // Compare process: advance the model on each edge, check the DUT just after it.
  always begin
    bit ev;
    @(posedge clk);
    stepModel();
    #1;
    if (rstIn) begin
      ev = (mPhase == 1) && (mQ.size() > 0);
      checkOutput("model out_valid", int'(out_valid), int'(ev));
      checkOutput("model out_addr", int'(out_addr), ev ? mQ[0] : 0);
      checkOutput("model busy", int'(busy), int'(mPhase == 1));
      checkOutput("model done", int'(done), int'(mPhase == 2));
      checkOutput("model no_match", int'(no_match), int'(mNm));
      checkOutput("model match_cnt", int'(match_cnt), mCnt);
    end
  end

  // Pulses start for one cycle; returns at the negedge where the first address is visible.
  task automatic applyStimulus(input logic [15:0] tag, input logic fo);
    @(negedge clk);
    tag_row    = tag;
    first_only = fo;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
  endtask

  initial begin
    int seq[4];
    rstIn      = 1'b0;
    tag_row    = '0;
    start      = 1'b0;
    first_only = 1'b0;
    abort      = 1'b0;
    out_ready  = 1'b1;
    resetModel();
    repeat (2) @(negedge clk);
    checkOutput("reset out_valid", int'(out_valid), 0);
    checkOutput("reset busy", int'(busy), 0);
    checkOutput("reset match_cnt", int'(match_cnt), 0);
    rstIn = 1'b1;

    // All-matches drain of 16'h8421.
    seq = '{0, 5, 10, 15};
    applyStimulus(16'h8421, 1'b0);
    tag_row = 16'hFFFF;
    for (int i = 0; i < 4; i++) begin
      checkOutput("drain out_valid", int'(out_valid), 1);
      checkOutput("drain out_addr", int'(out_addr), seq[i]);
      @(negedge clk);
    end
    checkOutput("drain done", int'(done), 1);
    checkOutput("drain match_cnt", int'(match_cnt), 4);
    checkOutput("drain no_match", int'(no_match), 0);
    @(negedge clk);
    checkOutput("drain done cleared", int'(done), 0);
    checkOutput("drain cnt held", int'(match_cnt), 4);

    // Zero tag: one empty SCAN cycle then done with no_match.
    applyStimulus(16'h0000, 1'b0);
    checkOutput("zero busy", int'(busy), 1);
    checkOutput("zero out_valid", int'(out_valid), 0);
    @(negedge clk);
    checkOutput("zero done", int'(done), 1);
    checkOutput("zero no_match", int'(no_match), 1);
    checkOutput("zero match_cnt", int'(match_cnt), 0);
    @(negedge clk);
    checkOutput("zero no_match held", int'(no_match), 1);

    // First-only mode.
    applyStimulus(16'h00F0, 1'b1);
    checkOutput("first out_addr", int'(out_addr), 4);
    @(negedge clk);
    checkOutput("first done", int'(done), 1);
    checkOutput("first match_cnt", int'(match_cnt), 1);
    @(negedge clk);

    // Consumer stall for five cycles.
    out_ready = 1'b0;
    applyStimulus(16'h0003, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput("stall out_valid", int'(out_valid), 1);
      checkOutput("stall out_addr", int'(out_addr), 0);
      @(negedge clk);
    end
    out_ready = 1'b1;
    checkOutput("release addr0", int'(out_addr), 0);
    @(negedge clk);
    checkOutput("release addr1", int'(out_addr), 1);
    @(negedge clk);
    checkOutput("release done", int'(done), 1);
    checkOutput("release match_cnt", int'(match_cnt), 2);
    @(negedge clk);

    // Abort on the third handshake; a start during SCAN must not reload.
    applyStimulus(16'hFFFF, 1'b0);
    checkOutput("abort addr0", int'(out_addr), 0);
    tag_row = 16'h0001;
    start   = 1'b1;
    @(negedge clk);
    checkOutput("ignored start addr1", int'(out_addr), 1);
    start = 1'b0;
    @(negedge clk);
    checkOutput("abort addr2", int'(out_addr), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("abort busy", int'(busy), 0);
    checkOutput("abort done", int'(done), 0);
    checkOutput("abort match_cnt", int'(match_cnt), 2);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    checkOutput("idle abort done", int'(done), 0);
    checkOutput("idle abort cnt", int'(match_cnt), 2);

    // Asynchronous reset mid-SCAN, then normal restart.
    out_ready = 1'b0;
    applyStimulus(16'h0F00, 1'b0);
    checkOutput("pre-reset addr", int'(out_addr), 8);
    #2 rstIn = 1'b0;
    #1;
    checkOutput("async out_valid", int'(out_valid), 0);
    checkOutput("async out_addr", int'(out_addr), 0);
    checkOutput("async busy", int'(busy), 0);
    checkOutput("async match_cnt", int'(match_cnt), 0);
    #1 rstIn = 1'b1;
    @(negedge clk);
    checkOutput("post-reset done", int'(done), 0);
    checkOutput("post-reset busy", int'(busy), 0);
    out_ready = 1'b1;
    applyStimulus(16'h0002, 1'b0);
    checkOutput("restart addr", int'(out_addr), 1);
    @(negedge clk);
    checkOutput("restart done", int'(done), 1);
    checkOutput("restart match_cnt", int'(match_cnt), 1);
    repeat (2) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
